// File: rtl/dma_writer_pkg.sv
// Shared types and helpers for the DMA line writer: FSM encoding,
// index-word field widths and the index-word packing function.
package dma_writer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC     = 2'd1,
    BURST    = 2'd2,
    LINE_END = 2'd3
  } state_t;

  localparam int IDX_BUF_W  = 5;
  localparam int IDX_LINE_W = 24;
  localparam int IDX_W      = IDX_BUF_W + IDX_LINE_W;

  // Build the CPU-visible index word: last completed buffer over line count.
  function automatic logic [IDX_W-1:0] idx_pack(input logic [IDX_BUF_W-1:0]  buf_idx,
                                                input logic [IDX_LINE_W-1:0] lines);
    return {buf_idx, lines};
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Buffer/line/word position tracking for the line writer. The byte address
// is kept as a register that steps one burst at a time; because lines and
// buffers are laid out back to back, stepping past the last burst of a line
// lands on the next line (or next buffer) base, and only the end of the
// ring needs an explicit jump back to BASE_ADDR.
module dma_addr_gen
  import dma_writer_pkg::*;
#(
  parameter int          LINE_WORDS    = 2048,
  parameter int          LINES_PER_BUF = 1024,
  parameter int          NUM_BUF       = 4,
  parameter int          BURST_LEN     = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 beat_acc,
  input  logic                 line_end,
  output logic [31:0]          avm_address,
  output logic                 last_beat,
  output logic                 buf_wrap,
  output logic [IDX_BUF_W-1:0] cur_buf
);

  localparam int WORD_W = (LINE_WORDS > 1)    ? $clog2(LINE_WORDS)    : 1;
  localparam int LINE_W = (LINES_PER_BUF > 1) ? $clog2(LINES_PER_BUF) : 1;
  localparam int BUF_W  = (NUM_BUF > 1)       ? $clog2(NUM_BUF)       : 1;

  localparam logic [WORD_W-1:0] WORD_LAST   = WORD_W'(LINE_WORDS - 1);
  localparam logic [WORD_W-1:0] BURST_MASK  = WORD_W'(BURST_LEN - 1);
  localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(LINES_PER_BUF - 1);
  localparam logic [BUF_W-1:0]  BUF_LAST    = BUF_W'(NUM_BUF - 1);
  localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * 4);

  logic [WORD_W-1:0] word_ptr_r;
  logic [LINE_W-1:0] line_ptr_r;
  logic [BUF_W-1:0]  buf_ptr_r;
  logic [31:0]       addr_r;
  logic              burst_end_s;
  logic              ring_wrap_s;

  assign burst_end_s = ((word_ptr_r & BURST_MASK) == BURST_MASK);
  assign last_beat   = (word_ptr_r == WORD_LAST);
  assign buf_wrap    = (line_ptr_r == LINE_LAST);
  assign ring_wrap_s = buf_wrap & (buf_ptr_r == BUF_LAST);
  assign avm_address = addr_r;
  assign cur_buf     = IDX_BUF_W'(buf_ptr_r);

  // Word pointer within the line and burst-stepped byte address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_ptr_r <= {WORD_W{1'b0}};
      addr_r     <= BASE_ADDR;
    end else if (beat_acc) begin
      if (last_beat) begin
        word_ptr_r <= {WORD_W{1'b0}};
      end else begin
        word_ptr_r <= word_ptr_r + WORD_W'(1);
      end
      if (burst_end_s) begin
        if (last_beat && ring_wrap_s) begin
          addr_r <= BASE_ADDR;
        end else begin
          addr_r <= addr_r + BURST_BYTES;
        end
      end else begin
        addr_r <= addr_r;
      end
    end else begin
      word_ptr_r <= word_ptr_r;
      addr_r     <= addr_r;
    end
  end

  // Line and buffer pointers advance once per completed line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_ptr_r <= {LINE_W{1'b0}};
      buf_ptr_r  <= {BUF_W{1'b0}};
    end else if (line_end) begin
      if (buf_wrap) begin
        line_ptr_r <= {LINE_W{1'b0}};
        if (buf_ptr_r == BUF_LAST) begin
          buf_ptr_r <= {BUF_W{1'b0}};
        end else begin
          buf_ptr_r <= buf_ptr_r + BUF_W'(1);
        end
      end else begin
        line_ptr_r <= line_ptr_r + LINE_W'(1);
        buf_ptr_r  <= buf_ptr_r;
      end
    end else begin
      line_ptr_r <= line_ptr_r;
      buf_ptr_r  <= buf_ptr_r;
    end
  end

endmodule

// File: rtl/dma_line_writer.sv
// Streams scanner lines into a ring of SDRAM frame buffers through an
// Avalon-MM burst write master and publishes progress on dma_indexes.
// The stream handshake passes straight through to the Avalon write so a
// beat costs no extra cycle; the index word and line pulse are registered.
module dma_line_writer
  import dma_writer_pkg::*;
#(
  parameter int          LINE_WORDS    = 2048,
  parameter int          LINES_PER_BUF = 1024,
  parameter int          NUM_BUF       = 4,
  parameter int          BURST_LEN     = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [31:0]      st_data,
  input  logic             st_valid,
  input  logic             st_sop,
  output logic             st_ready,
  output logic [31:0]      avm_address,
  output logic [6:0]       avm_burstcount,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic [3:0]       avm_byteenable,
  input  logic             avm_waitrequest,
  output logic [IDX_W-1:0] dma_indexes,
  output logic             line_irq
);

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   st_ready_s;
  logic                   avm_write_s;
  logic                   beat_acc_s;
  logic                   line_end_s;
  logic                   line_done_s;
  logic                   last_beat_s;
  logic                   buf_wrap_s;
  logic [IDX_BUF_W-1:0]   cur_buf_s;
  logic [IDX_W-1:0]       dma_idx_r;
  logic                   line_irq_r;

  dma_addr_gen #(
    .LINE_WORDS    (LINE_WORDS),
    .LINES_PER_BUF (LINES_PER_BUF),
    .NUM_BUF       (NUM_BUF),
    .BURST_LEN     (BURST_LEN),
    .BASE_ADDR     (BASE_ADDR)
  ) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .beat_acc    (beat_acc_s),
    .line_end    (line_end_s),
    .avm_address (avm_address),
    .last_beat   (last_beat_s),
    .buf_wrap    (buf_wrap_s),
    .cur_buf     (cur_buf_s)
  );

  assign st_ready       = st_ready_s;
  assign avm_write      = avm_write_s;
  assign avm_writedata  = st_data;
  assign avm_burstcount = 7'(BURST_LEN);
  assign avm_byteenable = 4'hF;
  assign line_done_s    = beat_acc_s & last_beat_s;
  assign dma_indexes    = dma_idx_r;
  assign line_irq       = line_irq_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and handshake muxing between stream and Avalon.
  always_comb begin
    next_state_s = state_r;
    st_ready_s   = 1'b0;
    avm_write_s  = 1'b0;
    beat_acc_s   = 1'b0;
    line_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          next_state_s = SYNC;
        end else begin
          next_state_s = IDLE;
        end
      end
      SYNC: begin
        // Drop words until a start-of-line, which is held for BURST.
        st_ready_s = ~(st_valid & st_sop);
        if (!enable) begin
          next_state_s = IDLE;
        end else if (st_valid && st_sop) begin
          next_state_s = BURST;
        end else begin
          next_state_s = SYNC;
        end
      end
      BURST: begin
        avm_write_s = st_valid;
        st_ready_s  = ~avm_waitrequest;
        beat_acc_s  = st_valid & ~avm_waitrequest;
        if (beat_acc_s && last_beat_s) begin
          next_state_s = LINE_END;
        end else begin
          next_state_s = BURST;
        end
      end
      LINE_END: begin
        line_end_s = 1'b1;
        if (enable) begin
          next_state_s = SYNC;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Index word and line pulse, updated on the clock after a line's final beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_idx_r  <= {IDX_W{1'b0}};
      line_irq_r <= 1'b0;
    end else begin
      line_irq_r <= line_done_s;
      if (line_done_s) begin
        dma_idx_r <= idx_pack(buf_wrap_s ? cur_buf_s : dma_idx_r[IDX_W-1:IDX_LINE_W],
                              dma_idx_r[IDX_LINE_W-1:0] + IDX_LINE_W'(1));
      end else begin
        dma_idx_r <= dma_idx_r;
      end
    end
  end

endmodule
